// File: rtl/ram_ctrl.sv
// Request sequencer for a 1K x 8 single-port RAM with a shared tristate data bus.
// Optional write-verify re-read is compiled in with RAM_CTRL_WRITE_VERIFY_EN.
module ram_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              verify_err,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic              ram_cs
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_TURN,
    S_RD1,
    S_RD2,
    S_RESP
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    ,
    S_VRD1,
    S_VRD2,
    S_VCHK
`endif
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_cs_nxt;
  logic                w_rd_nxt;
  logic                w_wr_nxt;
  logic                r_oe;
  logic                r_cs;
  logic                r_rd;
  logic                r_wr;
  logic                r_rsp_vld;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_next   = r_state;
    w_cs_nxt = 1'b0;
    w_rd_nxt = 1'b0;
    w_wr_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = req_we ? S_WR : S_RD1;
      end
      S_WR:   w_next = S_TURN;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      S_TURN: w_next = S_VRD1;
      S_VRD1: w_next = S_VRD2;
      S_VRD2: w_next = S_VCHK;
      S_VCHK: w_next = S_IDLE;
`else
      S_TURN: w_next = S_IDLE;
`endif
      S_RD1:  w_next = S_RD2;
      S_RD2:  w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Strobes are decoded from the next state so the flops line up with the state they belong to.
    case (w_next)
      S_WR: begin
        w_cs_nxt = 1'b1;
        w_wr_nxt = 1'b1;
      end
      S_RD1, S_RD2: begin
        w_cs_nxt = 1'b1;
        w_rd_nxt = 1'b1;
      end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      S_VRD1, S_VRD2: begin
        w_cs_nxt = 1'b1;
        w_rd_nxt = 1'b1;
      end
`endif
      default: begin
        w_cs_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cs      <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_oe      <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_cs      <= w_cs_nxt;
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_oe      <= w_wr_nxt;
      r_rsp_vld <= (r_state == S_RD2);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_RD2) r_rdata <= ram_data;
    end
  end

`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic [DATA_W-1:0] r_vdata;
  logic              r_verr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vdata <= '0;
      r_verr  <= 1'b0;
    end else begin
      if (r_state == S_VRD2) r_vdata <= ram_data;
      if ((r_state == S_VCHK) && (r_vdata != r_wdata)) r_verr <= 1'b1;
    end
  end

  assign verify_err = r_verr;
`else
  assign verify_err = 1'b0;
`endif

  assign ram_data  = r_oe ? r_wdata : {DATA_W{1'bz}};
  assign ram_addr  = r_addr;
  assign ram_cs    = r_cs;
  assign ram_rd    = r_rd;
  assign ram_wr    = r_wr;
  assign rsp_valid = r_rsp_vld;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares RAM strobes and read responses.
module tb_ram_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  localparam int WR_CYC = 6;
`else
  localparam int WR_CYC = 3;
`endif
  localparam int RD_CYC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          verify_err;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_rd;
  logic          ram_wr;
  logic          ram_cs;

  ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .verify_err(verify_err),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_cs(ram_cs)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read onto the bus, write captured on posedge.
  logic [DW-1:0] mem [0:1023];
  logic          force_zero = 1'b0;
  assign ram_data = (ram_cs && ram_rd && !ram_wr) ? (force_zero ? 8'h00 : mem[ram_addr]) : 8'hzz;
  always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [DW-1:0] data; int cyc; } rexp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wexp_t;
  rexp_t rdq[$];
  wexp_t wrq[$];
  logic [AW-1:0] exp_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (rdq.size() == 0) chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        else begin
          rexp_t e;
          e = rdq.pop_front();
          chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
      if (ram_wr) begin
        if (wrq.size() == 0) chk("unexpected_wr", {31'd0, ram_wr}, 32'd0);
        else begin
          wexp_t w;
          w = wrq.pop_front();
          chk("wr_addr", {22'd0, ram_addr}, {22'd0, w.addr});
          chk("wr_data", {24'd0, ram_data}, {24'd0, w.data});
          chk("wr_cs", {31'd0, ram_cs}, 32'd1);
          chk("wr_rd_low", {31'd0, ram_rd}, 32'd0);
          chk("wr_cycle", cyc, w.cyc);
        end
      end
      if (ram_rd) begin
        chk("rd_addr", {22'd0, ram_addr}, {22'd0, exp_addr});
        chk("rd_cs", {31'd0, ram_cs}, 32'd1);
      end
      if (busy) begin
        chk("busy_addr", {22'd0, ram_addr}, {22'd0, exp_addr});
        chk("ready_when_busy", {31'd0, req_ready}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge, req_valid still high.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rd, input bit push, output int n);
    int guard;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    n = cyc + 1;
    @(posedge clk);
    exp_addr = addr;
    if (push) begin
      if (we) wrq.push_back('{addr, wdata, n});
      else    rdq.push_back('{exp_rd, n + 2});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    req_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, n1, n2, n3;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_verify_err", {31'd0, verify_err}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back at addr 5
    do_req(1'b1, 10'd5, 8'hAA, 8'h00, 1'b1, n0);
    do_req(1'b0, 10'd5, 8'h00, 8'hAA, 1'b1, n1);
    chk("wr_to_rd_interval", n1 - n0, WR_CYC);
    idle(6);

    // Two writes, two reads
    do_req(1'b1, 10'd10, 8'h55, 8'h00, 1'b1, n0);
    do_req(1'b1, 10'd5,  8'hAA, 8'h00, 1'b1, n1);
    do_req(1'b0, 10'd10, 8'h00, 8'h55, 1'b1, n2);
    do_req(1'b0, 10'd5,  8'h00, 8'hAA, 1'b1, n3);
    chk("wr_wr_interval", n1 - n0, WR_CYC);
    chk("rd_rd_interval", n3 - n2, RD_CYC);
    idle(6);

    // Valid held high, alternating write/read
    do_req(1'b1, 10'h100, 8'h12, 8'h00, 1'b1, n0);
    do_req(1'b0, 10'h100, 8'h00, 8'h12, 1'b1, n1);
    do_req(1'b1, 10'h101, 8'h34, 8'h00, 1'b1, n2);
    do_req(1'b0, 10'h101, 8'h00, 8'h34, 1'b1, n3);
    chk("alt_wr_interval", n1 - n0, WR_CYC);
    chk("alt_rd_interval", n2 - n1, RD_CYC);
    chk("alt_wr_interval2", n3 - n2, WR_CYC);
    idle(6);

    // Top address
    do_req(1'b1, 10'h3FF, 8'hC3, 8'h00, 1'b1, n0);
    do_req(1'b0, 10'h3FF, 8'h00, 8'hC3, 1'b1, n1);
    idle(6);
    chk("top_addr_held", {22'd0, ram_addr}, 32'h3FF);

    // Reset during RD2: transaction abandoned, no response
    do_req(1'b0, 10'd10, 8'h00, 8'h00, 1'b0, n0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rd2_rd_high", {31'd0, ram_rd}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rdata", {24'd0, rsp_rdata}, 32'd0);

    // Recovery read of earlier data
    do_req(1'b0, 10'd5, 8'h00, 8'hAA, 1'b1, n0);
    idle(6);

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    chk("verify_ok", {31'd0, verify_err}, 32'd0);
    force_zero = 1'b1;
    do_req(1'b1, 10'h20, 8'hAA, 8'h00, 1'b1, n0);
    idle(6);
    force_zero = 1'b0;
    chk("verify_err_set", {31'd0, verify_err}, 32'd1);
    do_req(1'b1, 10'h21, 8'h11, 8'h00, 1'b1, n0);
    idle(8);
    chk("verify_err_sticky", {31'd0, verify_err}, 32'd1);
`else
    chk("verify_err_tied", {31'd0, verify_err}, 32'd0);
`endif

    chk("rsp_queue_empty", rdq.size(), 32'd0);
    chk("wr_queue_empty", wrq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
